// File: rtl/riscboy_ppu_pkg.sv
// riscboy_ppu_pkg
// Shared definitions for the PPU shift scheduler: the FSM state encoding and
// the default datapath shift limits used as parameter defaults.
package riscboy_ppu_pkg;

  // Scheduler states. REWIND and UNSHIFT are only reachable when the rewind
  // feature is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_OUT     = 3'd2,
    ST_REWIND  = 3'd3,
    ST_UNSHIFT = 3'd4
  } shift_sched_state_e;

  // Maximum left shift of the attached datapath, in bits.
  localparam int PPU_SHIFT_MAX_DEFAULT     = 9;
  // Shift-amount width; 2**width must exceed the maximum shift.
  localparam int PPU_SHIFT_W_SHAMT_DEFAULT = 4;

endpackage

// File: rtl/riscboy_ppu_shift_sched_ctr.sv
// riscboy_ppu_shift_sched_ctr
// Loadable down-counter used to time runs of shift strobes.
// Ports:
//   clk, rst      clock and synchronous active-high reset (clears count)
//   i_load        load strobe, takes priority over decrement
//   i_load_val    value loaded on i_load
//   i_dec         decrement enable; the count holds at zero
//   o_zero        high when the count is zero
module riscboy_ppu_shift_sched_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Count register: reset, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/riscboy_ppu_shift_sched.sv
// riscboy_ppu_shift_sched
// Sequences load/shift/unshift strobes for an external left-shift datapath.
// A request latches a (saturated) shift amount, emits that many sr_shift
// strobes, then presents the result until it is accepted. With the rewind
// feature, accepting a result may instead shift the rest of the way to
// MAX_SHIFT, unshift once, and reshift by a new amount.
// Configuration macro: RISCBOY_PPU_SHIFT_SCHED_REWIND_EN enables rewind.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready/in_shamt  request handshake and shift amount
//   out_valid/out_ready         result handshake (datapath output valid)
//   out_rewind/out_rewind_shamt rewind request qualifying a result accept
//   sr_load/sr_shift/sr_unshift datapath strobes, mutually exclusive
//   busy                        high whenever not idle
module riscboy_ppu_shift_sched
  import riscboy_ppu_pkg::*;
#(
  parameter int MAX_SHIFT = PPU_SHIFT_MAX_DEFAULT,
  parameter int W_SHAMT   = PPU_SHIFT_W_SHAMT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_SHAMT-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               out_rewind,
  input  logic [W_SHAMT-1:0] out_rewind_shamt,
  output logic               sr_load,
  output logic               sr_shift,
  output logic               sr_unshift,
  output logic               busy
);

  localparam logic [W_SHAMT-1:0] L_MAX = W_SHAMT'(MAX_SHIFT);

  shift_sched_state_e r_state;
  shift_sched_state_e w_state_nxt;
  logic [W_SHAMT-1:0] r_cur_shamt;
  logic [W_SHAMT-1:0] w_cur_nxt;
  logic [W_SHAMT-1:0] w_in_sat;
  logic               w_ctr_load;
  logic [W_SHAMT-1:0] w_ctr_val;
  logic               w_ctr_dec;
  logic               w_ctr_zero;

  assign w_in_sat = (in_shamt > L_MAX) ? L_MAX : in_shamt;

`ifdef RISCBOY_PPU_SHIFT_SCHED_REWIND_EN
  logic [W_SHAMT-1:0] r_new_shamt;
  logic [W_SHAMT-1:0] w_new_nxt;
  logic [W_SHAMT-1:0] w_rw_sat;
  logic [W_SHAMT-1:0] w_rw_cnt;

  assign w_rw_sat = (out_rewind_shamt > L_MAX) ? L_MAX : out_rewind_shamt;
  // Shifts needed to bring the current result to the full MAX_SHIFT.
  assign w_rw_cnt = L_MAX - r_cur_shamt;
`else
  // Rewind inputs have no function in this build.
  logic w_unused_rewind;
  assign w_unused_rewind = ^{out_rewind, out_rewind_shamt};
`endif

  // The counter is loaded with (run length - 1) so that a run ends in the
  // cycle where the zero flag is already set.
  riscboy_ppu_shift_sched_ctr #(
    .W (W_SHAMT)
  ) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ctr_load),
    .i_load_val (w_ctr_val),
    .i_dec      (w_ctr_dec),
    .o_zero     (w_ctr_zero)
  );

  // State and shift-amount registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur_shamt <= '0;
`ifdef RISCBOY_PPU_SHIFT_SCHED_REWIND_EN
      r_new_shamt <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cur_shamt <= w_cur_nxt;
`ifdef RISCBOY_PPU_SHIFT_SCHED_REWIND_EN
      r_new_shamt <= w_new_nxt;
`endif
    end
  end

  // Next-state, shift-amount and counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_shamt;
    w_ctr_load  = 1'b0;
    w_ctr_val   = '0;
    w_ctr_dec   = 1'b0;
`ifdef RISCBOY_PPU_SHIFT_SCHED_REWIND_EN
    w_new_nxt   = r_new_shamt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_cur_nxt = w_in_sat;
          if (w_in_sat != '0) begin
            w_ctr_load  = 1'b1;
            w_ctr_val   = w_in_sat - W_SHAMT'(1);
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_OUT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_ctr_zero) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_ctr_dec = 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
`ifdef RISCBOY_PPU_SHIFT_SCHED_REWIND_EN
          if (out_rewind) begin
            w_new_nxt = w_rw_sat;
            if (w_rw_cnt != '0) begin
              w_ctr_load  = 1'b1;
              w_ctr_val   = w_rw_cnt - W_SHAMT'(1);
              w_state_nxt = ST_REWIND;
            end else begin
              w_state_nxt = ST_UNSHIFT;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
`ifdef RISCBOY_PPU_SHIFT_SCHED_REWIND_EN
      ST_REWIND: begin
        if (w_ctr_zero) begin
          w_state_nxt = ST_UNSHIFT;
        end else begin
          w_ctr_dec = 1'b1;
        end
      end
      ST_UNSHIFT: begin
        w_cur_nxt = r_new_shamt;
        if (r_new_shamt != '0) begin
          w_ctr_load  = 1'b1;
          w_ctr_val   = r_new_shamt - W_SHAMT'(1);
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign in_ready   = (r_state == ST_IDLE);
  // Gated with rst so no load strobe escapes while reset is held.
  assign sr_load    = in_valid & in_ready & ~rst;
  assign out_valid  = (r_state == ST_OUT);
  assign busy       = (r_state != ST_IDLE);
`ifdef RISCBOY_PPU_SHIFT_SCHED_REWIND_EN
  assign sr_shift   = (r_state == ST_SHIFT) || (r_state == ST_REWIND);
  assign sr_unshift = (r_state == ST_UNSHIFT);
`else
  assign sr_shift   = (r_state == ST_SHIFT);
  assign sr_unshift = 1'b0;
`endif

endmodule

// File: tb/tb_riscboy_ppu_shift_sched.sv
// Testbench for riscboy_ppu_shift_sched with a behavioural 18-bit shift
// datapath attached (din = 18'h00abc). Expected datapath outputs are pushed
// to a scoreboard queue when a request is issued and popped when out_valid
// appears.
module tb_riscboy_ppu_shift_sched;

  localparam logic [17:0] DIN = 18'h00abc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_shamt;
  logic       out_valid;
  logic       out_ready;
  logic       out_rewind;
  logic [3:0] out_rewind_shamt;
  logic       sr_load;
  logic       sr_shift;
  logic       sr_unshift;
  logic       busy;

  logic [17:0] r_dp;
  logic [17:0] r_base;
  logic [17:0] sb_q[$];
  int          vectors;
  int          errors;

  riscboy_ppu_shift_sched #(
    .MAX_SHIFT (9),
    .W_SHAMT   (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_shamt         (in_shamt),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_rewind       (out_rewind),
    .out_rewind_shamt (out_rewind_shamt),
    .sr_load          (sr_load),
    .sr_shift         (sr_shift),
    .sr_unshift       (sr_unshift),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External datapath: load din, shift left by one, or restore din.
  always_ff @(posedge clk) begin
    if (sr_load) begin
      r_dp   <= DIN;
      r_base <= DIN;
    end else if (sr_shift) begin
      r_dp <= {r_dp[16:0], 1'b0};
    end else if (sr_unshift) begin
      r_dp <= r_base;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] shifted(input int s);
    logic [17:0] v;
    v = DIN << s;
    return v;
  endfunction

  function automatic int sat(input int s);
    return (s > 9) ? 9 : s;
  endfunction

  // Follow strobes until out_valid; counts shifts before/after the unshift.
  task automatic wait_out(input string tag, output int pre, output int unsh,
                          output int post, output int lat);
    bit done;
    pre = 0; unsh = 0; post = 0; lat = 1; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (out_valid) begin
        done = 1'b1;
      end else begin
        chk({tag, "_excl"}, 32'(sr_load) + 32'(sr_shift) + 32'(sr_unshift) <= 32'd1, 32'd1);
        if (sr_unshift) unsh++;
        else if (sr_shift && unsh == 0) pre++;
        else if (sr_shift) post++;
        tick();
        lat++;
      end
    end
    chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic pop_dout(input string tag);
    logic [17:0] e;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_dout"}, 32'(r_dp), 32'(e));
    end
  endtask

  // Issue a request from IDLE and follow it to OUT.
  task automatic run_req(input string tag, input int s);
    int pre, unsh, post, lat;
    in_valid = 1'b1;
    in_shamt = 4'(s);
    #1;
    chk({tag, "_sr_load"}, 32'(sr_load), 32'd1);
    sb_q.push_back(shifted(sat(s)));
    tick();
    in_valid = 1'b0;
    wait_out(tag, pre, unsh, post, lat);
    chk({tag, "_shifts"}, 32'(pre), 32'(sat(s)));
    chk({tag, "_unshift"}, 32'(unsh), 32'd0);
    chk({tag, "_latency"}, 32'(lat), 32'(1 + sat(s)));
    pop_dout(tag);
  endtask

  // Accept the result currently presented in OUT.
  task automatic accept_out(input string tag, input logic rw, input int rs);
    out_ready        = 1'b1;
    out_rewind       = rw;
    out_rewind_shamt = 4'(rs);
    #1;
    chk({tag, "_acc_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_acc_out_valid"}, 32'(out_valid), 32'd1);
    tick();
    out_ready  = 1'b0;
    out_rewind = 1'b0;
  endtask

  initial begin
    int pre, unsh, post, lat;
    vectors = 0;
    errors  = 0;
    rst = 1'b1; in_valid = 1'b0; in_shamt = 4'd0;
    out_ready = 1'b0; out_rewind = 1'b0; out_rewind_shamt = 4'd0;
    tick();
    tick();

    // Reset state, with a request pending that must not load.
    in_valid = 1'b1;
    in_shamt = 4'd3;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sr_load", 32'(sr_load), 32'd0);
    chk("rst_strobes", 32'({sr_shift, sr_unshift, out_valid, busy}), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Basic shift of 3, then plain accept back to IDLE.
    run_req("s3", 3);
    accept_out("s3", 1'b0, 0);
    chk("s3_idle", 32'(in_ready), 32'd1);
    chk("s3_not_busy", 32'(busy), 32'd0);

    // Zero shift: straight to OUT, then hold with out_ready low.
    run_req("s0", 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_strobes", 32'({sr_load, sr_shift, sr_unshift, in_ready}), 32'd0);
      tick();
    end
    accept_out("s0", 1'b0, 0);
    chk("s0_idle", 32'(in_ready), 32'd1);

    // Saturation: 12 requests only 9 shifts.
    run_req("s12", 12);
    accept_out("s12", 1'b0, 0);

    // Reset during the second SHIFT cycle of a shift-by-5.
    in_valid = 1'b1;
    in_shamt = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_second_shift", 32'(sr_shift), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_strobes", 32'({sr_shift, sr_unshift, out_valid, busy}), 32'd0);
    tick();
    chk("mid_rst_quiet", 32'({sr_load, sr_shift, sr_unshift, out_valid, busy}), 32'd0);

`ifdef RISCBOY_PPU_SHIFT_SCHED_REWIND_EN
    // Rewind from shamt 3 to shamt 5: 6 shifts, unshift, 5 shifts.
    run_req("rw3", 3);
    sb_q.push_back(shifted(5));
    accept_out("rw3", 1'b1, 5);
    wait_out("rw3", pre, unsh, post, lat);
    chk("rw3_rewind_shifts", 32'(pre), 32'd6);
    chk("rw3_unshift", 32'(unsh), 32'd1);
    chk("rw3_reshifts", 32'(post), 32'd5);
    pop_dout("rw3");
    accept_out("rw3_done", 1'b0, 0);

    // Rewind at full shift: no REWIND cycles, UNSHIFT immediately.
    run_req("rw9", 12);
    sb_q.push_back(shifted(2));
    accept_out("rw9", 1'b1, 2);
    chk("rw9_unshift_next", 32'(sr_unshift), 32'd1);
    wait_out("rw9", pre, unsh, post, lat);
    chk("rw9_rewind_shifts", 32'(pre), 32'd0);
    chk("rw9_unshift", 32'(unsh), 32'd1);
    chk("rw9_reshifts", 32'(post), 32'd2);
    chk("rw9_latency", 32'(lat), 32'd4);
    pop_dout("rw9");
    accept_out("rw9_done", 1'b0, 0);
`else
    // Rewind disabled: a rewind accept simply returns to IDLE.
    run_req("norw", 3);
    accept_out("norw", 1'b1, 5);
    chk("norw_idle", 32'(in_ready), 32'd1);
    chk("norw_strobes", 32'({sr_shift, sr_unshift, busy}), 32'd0);
    tick();
    chk("norw_quiet", 32'({sr_shift, sr_unshift, out_valid, busy}), 32'd0);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
